// File: rtl/spi_flash_loader.sv
// SPI NOR boot loader: issues READ (0x03 + 24-bit address), streams NUM_WORDS words
// from the flash and writes each to consecutive Wishbone addresses, with host bypass.
module spi_flash_loader #(
  parameter int          CLK_DIV     = 4,
  parameter int          DATA_W      = 32,
  parameter int          NUM_WORDS   = 16,
  parameter logic [23:0] FLASH_ADDR  = 24'h000000,
  parameter logic [31:0] WB_BASE     = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        bypass_en,
  input  logic        host_mosi,
  input  logic        host_clk,
  input  logic        host_csb,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_clk,
  output logic        flash_csb,
  output logic [31:0] wbs_adr,
  output logic [31:0] wbs_dat,
  output logic        wbs_cyc,
  output logic        wbs_stb,
  output logic        wbs_we,
  input  logic        wbs_ack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [5:0]       BITS_LAST = 6'(DATA_W);
  localparam logic [31:0]      FRAME     = {8'h03, FLASH_ADDR};
  localparam logic [31:0]      WORD_STEP = 32'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_READ = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              state_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic                sclk_r;
  logic                csb_r;
  logic                mosi_r;
  logic [31:0]         frame_r;
  logic [5:0]          bit_cnt_r;
  logic [DATA_W-1:0]   word_r;
  logic [IDX_W-1:0]    idx_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic                cyc_r;
  logic                stb_r;
  logic                we_r;
  logic [31:0]         adr_r;
  logic [31:0]         dat_r;
  logic                busy_r;
  logic                done_r;
  logic                error_r;
  logic                armed_r;
  logic                tick_s;
  logic                start_ok_s;

  assign tick_s     = (div_cnt_r == DIV_LAST);
  // armed_r masks a start pulse that coincides with the first edge after reset release
  assign start_ok_s = start & armed_r & ~bypass_en &
                      ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERR));

  // Loader state machine, SPI sequencer and Wishbone master
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
      csb_r     <= 1'b1;
      mosi_r    <= 1'b0;
      frame_r   <= 32'h0000_0000;
      bit_cnt_r <= 6'd0;
      word_r    <= '0;
      idx_r     <= '0;
      to_cnt_r  <= '0;
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      we_r      <= 1'b0;
      adr_r     <= 32'h0000_0000;
      dat_r     <= 32'h0000_0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      armed_r <= 1'b1;
      if (bypass_en) begin
        state_r   <= S_IDLE;
        div_cnt_r <= '0;
        sclk_r    <= 1'b0;
        csb_r     <= 1'b1;
        mosi_r    <= 1'b0;
        bit_cnt_r <= 6'd0;
        idx_r     <= '0;
        to_cnt_r  <= '0;
        cyc_r     <= 1'b0;
        stb_r     <= 1'b0;
        we_r      <= 1'b0;
        adr_r     <= 32'h0000_0000;
        dat_r     <= 32'h0000_0000;
        busy_r    <= 1'b0;
        done_r    <= 1'b0;
      end else if (start_ok_s) begin
        state_r   <= S_CMD;
        div_cnt_r <= '0;
        sclk_r    <= 1'b0;
        csb_r     <= 1'b0;
        mosi_r    <= FRAME[31];
        frame_r   <= FRAME;
        bit_cnt_r <= 6'd0;
        idx_r     <= '0;
        to_cnt_r  <= '0;
        busy_r    <= 1'b1;
        done_r    <= 1'b0;
        error_r   <= 1'b0;
      end else begin
        case (state_r)
          S_CMD, S_READ: begin
            if (tick_s) begin
              div_cnt_r <= '0;
              sclk_r    <= ~sclk_r;
              if (!sclk_r) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                if (state_r == S_READ) begin
                  word_r <= {word_r[DATA_W-2:0], flash_miso};
                end else begin
                  word_r <= word_r;
                end
              end else if (state_r == S_CMD) begin
                if (bit_cnt_r == 6'd32) begin
                  state_r   <= S_READ;
                  mosi_r    <= 1'b0;
                  bit_cnt_r <= 6'd0;
                end else begin
                  mosi_r  <= frame_r[30];
                  frame_r <= {frame_r[30:0], 1'b0};
                end
              end else if (bit_cnt_r == BITS_LAST) begin
                // clock parks low with csb still asserted so the flash stream only pauses
                state_r   <= S_WB;
                bit_cnt_r <= 6'd0;
              end else begin
                bit_cnt_r <= bit_cnt_r;
              end
            end else begin
              div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
          end
          S_WB: begin
            if (!stb_r) begin
              cyc_r    <= 1'b1;
              stb_r    <= 1'b1;
              we_r     <= 1'b1;
              adr_r    <= WB_BASE + (32'(idx_r) * WORD_STEP);
              dat_r    <= 32'(word_r);
              to_cnt_r <= '0;
            end else if (wbs_ack) begin
              cyc_r <= 1'b0;
              stb_r <= 1'b0;
              we_r  <= 1'b0;
              idx_r <= idx_r + IDX_W'(1);
              if (idx_r == IDX_LAST) begin
                state_r <= S_DONE;
                csb_r   <= 1'b1;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                state_r   <= S_READ;
                div_cnt_r <= '0;
              end
            end else if (to_cnt_r == TO_LAST) begin
              state_r <= S_ERR;
              cyc_r   <= 1'b0;
              stb_r   <= 1'b0;
              we_r    <= 1'b0;
              csb_r   <= 1'b1;
              sclk_r  <= 1'b0;
              busy_r  <= 1'b0;
              error_r <= 1'b1;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          S_IDLE, S_DONE, S_ERR: ;
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  assign flash_mosi = bypass_en ? host_mosi : mosi_r;
  assign flash_clk  = bypass_en ? host_clk  : sclk_r;
  assign flash_csb  = bypass_en ? host_csb  : csb_r;
  assign wbs_adr    = adr_r;
  assign wbs_dat    = dat_r;
  assign wbs_cyc    = cyc_r;
  assign wbs_stb    = stb_r;
  assign wbs_we     = we_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: doc/spi_flash_loader.md
Name: spi_flash_loader

Overview:
- Parametrised next-generation flash boot loader for the NoC gateway.
- After a start pulse, it issues a standard SPI READ (0x03 + 24-bit address) to the external flash.
- It streams NUM_WORDS words of DATA_W bits from the flash and writes each word to consecutive Wishbone addresses starting at WB_BASE.
- It adds a programmable SPI clock divider, command generation, an ack timeout with error reporting, and a clean host bypass mux.

Parameters:
- CLK_DIV, 4: flash_clk half-period in clk cycles (>=1).
- DATA_W, 32: bits per word (multiple of 8, <=32).
- NUM_WORDS, 16: words per boot load (>=1).
- FLASH_ADDR, 24'h000000: flash start address sent after the command byte.
- WB_BASE, 32'h3000_0000: Wishbone byte address of the first word.
- ACK_TIMEOUT, 255: clk cycles to wait for wbs_ack before the block reports an error.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; honoured only in IDLE, DONE or ERR with bypass_en=0.
- bypass_en  in  1  1 = host drives the flash pins directly.
- host_mosi  in  1  host serial data (bypass).
- host_clk  in  1  host SPI clock (bypass).
- host_csb  in  1  host chip select (bypass).
- flash_miso  in  1  flash serial data out.
- flash_mosi  out  1  flash serial data in.
- flash_clk  out  1  SPI clock, mode 0.
- flash_csb  out  1  flash chip select, active-low.
- wbs_adr  out  32  Wishbone address.
- wbs_dat  out  32  Wishbone write data, zero-extended from DATA_W.
- wbs_cyc  out  1  Wishbone cycle.
- wbs_stb  out  1  Wishbone strobe.
- wbs_we  out  1  Wishbone write enable.
- wbs_ack  in  1  Wishbone acknowledge.
- busy  out  1  load in progress.
- done  out  1  load completed; held until next start.
- error  out  1  ack timeout; held until next start or reset.

Behaviour:
- Reset (reset=0, async): state=IDLE. Outputs: flash_csb=1, flash_clk=0, flash_mosi=0, wbs_cyc=wbs_stb=wbs_we=0, wbs_adr=0, wbs_dat=0, busy=done=error=0. Word index and bit counters clear.
- States: IDLE -> CMD -> READ -> WB -> (READ | DONE); WB -> ERR on timeout. DONE/ERR -> CMD on start.
- start in IDLE, DONE or ERR:
  - Next cycle: flash_csb=0, busy=1, done=error=0, state=CMD.
  - flash_mosi = bit 31 of frame {8'h03, FLASH_ADDR}.
- SPI timing, mode 0, MSB first:
  - flash_clk toggles every CLK_DIV clk cycles and idles low.
  - The first rising edge occurs CLK_DIV cycles after csb falls.
  - flash_mosi updates on falling edges.
  - flash_miso is sampled on rising edges.
- CMD: 32 bits shifted out. After the 32nd falling edge, state=READ and flash_mosi=0.
- READ:
  - DATA_W bits are sampled; the first sampled bit becomes word bit DATA_W-1.
  - After the DATA_W-th rising edge and the following falling edge, state=WB.
  - flash_clk is then held low and flash_csb held low, so the flash stream is paused, not restarted.
- WB:
  - Next cycle: wbs_cyc=wbs_stb=wbs_we=1, wbs_adr = WB_BASE + index*(DATA_W/8), wbs_dat = word.
  - These outputs stay stable until ack.
  - On the wbs_ack cycle: cyc/stb/we drop the next cycle and index increments.
  - If index < NUM_WORDS: return to READ; clocking resumes after CLK_DIV cycles.
  - Otherwise: flash_csb=1, busy=0, done=1, state=DONE.
  - wbs_ack outside WB is ignored.
- Timeout: the counter runs in WB while ack=0. If ACK_TIMEOUT cycles pass without ack:
  - cyc/stb/we=0, flash_csb=1, flash_clk=0.
  - busy=0, error=1, state=ERR.
- Bypass:
  - While bypass_en=1: flash_mosi=host_mosi, flash_clk=host_clk, flash_csb=host_csb (combinational mux).
  - The FSM is forced to IDLE: Wishbone outputs 0, busy=0, done=0, counters cleared, and start is ignored.
  - Asserting bypass mid-load aborts the load with no error.
  - After bypass_en falls, the block stays in IDLE until start.
- start while busy is ignored. A pulse received in the same cycle as reset release is ignored.
- Total SPI rising edges per load = 32 + NUM_WORDS*DATA_W.

Test Plan:
- Basic load: CLK_DIV=2, NUM_WORDS=2, flash model returns 0xDEADBEEF then 0x12345678, immediate ack -> MOSI carries 0x03000000, 96 rising edges, writes (0x30000000, DEADBEEF) then (0x30000004, 12345678), done=1, csb=1.
- Ack delayed 10 cycles -> flash_clk frozen low, csb low, adr/dat/cyc/stb stable for 10 cycles, then the stream resumes with no bit lost.
- No ack, ACK_TIMEOUT=255 -> exactly 255 cycles after stb rises: error=1, cyc=stb=0, csb=1; a subsequent start clears error and reloads from word 0.
- bypass_en=1 mid-READ -> same cycle flash pins follow host_*; next cycle cyc=0, busy=0; after release, start reloads from word 0.
- reset=0 asserted mid-WB, asynchronous to clk edge -> all outputs return to reset values immediately without waiting for a clk edge.
- CLK_DIV=1, DATA_W=8, NUM_WORDS=4, bytes A5,5A,FF,00 -> 4 writes to adr +0,+1,+2,+3 with dat 0xA5, 0x5A, 0xFF, 0x00; flash_clk period is 2 clk cycles.
